// File: rtl/rob_pkg.sv
// Shared sizing constants and the reorder-buffer entry layout for the commit stage.
package rob_pkg;
    localparam int unsigned SIZE           = 32;
    localparam int unsigned REG_NUM        = 64;
    localparam int unsigned ROB_DEPTH      = 16;
    localparam int unsigned COMPLETE_PORTS = 2;
    localparam int unsigned WRITE_PORTS    = 3;

    localparam int unsigned TAG_W = $clog2(ROB_DEPTH);
    localparam int unsigned REG_W = $clog2(REG_NUM);
    localparam int unsigned CNT_W = TAG_W + 1;
    localparam int unsigned N_W   = $clog2(WRITE_PORTS + 1);

    typedef struct packed {
        logic             valid;
        logic             done;
        logic             has_dest;
        logic [REG_W-1:0] dest;
        logic [SIZE-1:0]  data;
    } rob_entry_t;
endpackage

// File: rtl/rob_commit_if.sv
// Dispatch, completion, register-file write and status bundle of the commit stage.
interface rob_commit_if;
    import rob_pkg::*;

    logic                                     flush;
    logic                                     disp_valid;
    logic                                     disp_has_dest;
    logic [REG_W-1:0]                         disp_dest_reg;
    logic                                     disp_ready;
    logic [TAG_W-1:0]                         disp_tag;
    logic [COMPLETE_PORTS-1:0]                cmpl_valid;
    logic [COMPLETE_PORTS-1:0][TAG_W-1:0]     cmpl_tag;
    logic [COMPLETE_PORTS-1:0][SIZE-1:0]      cmpl_data;
    logic [WRITE_PORTS-1:0]                   RegWrite;
    logic [WRITE_PORTS-1:0][REG_W-1:0]        write_reg;
    logic [WRITE_PORTS-1:0][SIZE-1:0]         write_data;
    logic [TAG_W:0]                           count;
    logic                                     empty;

    modport master (
        output flush, disp_valid, disp_has_dest, disp_dest_reg, cmpl_valid, cmpl_tag, cmpl_data,
        input  disp_ready, disp_tag, RegWrite, write_reg, write_data, count, empty
    );

    modport slave (
        input  flush, disp_valid, disp_has_dest, disp_dest_reg, cmpl_valid, cmpl_tag, cmpl_data,
        output disp_ready, disp_tag, RegWrite, write_reg, write_data, count, empty
    );
endinterface

// File: rtl/rob_retire_select.sv
// Counts consecutive completed entries from the head, capped at the retire width.
module rob_retire_select
    import rob_pkg::*;
(
    input  logic [TAG_W-1:0]                    head,
    input  logic [ROB_DEPTH-1:0]                valid,
    input  logic [ROB_DEPTH-1:0]                done,
    output logic [N_W-1:0]                      n,
    output logic [WRITE_PORTS-1:0][TAG_W-1:0]   idx
);
    logic stop;

    always_comb begin
        n    = '0;
        stop = 1'b0;
        idx  = '0;
        for (int k = 0; k < WRITE_PORTS; k++) begin
            idx[k] = head + TAG_W'(k);
            // A valid entry implies it is occupied, so this also bounds n by count.
            if (!stop && valid[idx[k]] && done[idx[k]]) begin
                n = n + N_W'(1);
            end else begin
                stop = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rob_commit.sv
// In-order commit stage: circular reorder buffer with out-of-order completion and
// up to WRITE_PORTS in-order retirements per cycle into the register file.
module rob_commit
    import rob_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    rob_commit_if.slave  rif
);
    rob_entry_t                             entry_q [ROB_DEPTH];
    rob_entry_t                             entry_d [ROB_DEPTH];
    logic [TAG_W-1:0]                       head_q, head_d;
    logic [TAG_W-1:0]                       tail_q, tail_d;
    logic [CNT_W-1:0]                       count_q, count_d;
    logic [WRITE_PORTS-1:0]                 reg_write_q, reg_write_d;
    logic [WRITE_PORTS-1:0][REG_W-1:0]      write_reg_q, write_reg_d;
    logic [WRITE_PORTS-1:0][SIZE-1:0]       write_data_q, write_data_d;

    logic [ROB_DEPTH-1:0]                   valid_vec, done_vec;
    logic [N_W-1:0]                         ret_n;
    logic [WRITE_PORTS-1:0][TAG_W-1:0]      ret_idx;
    logic                                   accept;

    always_comb begin
        valid_vec = '0;
        done_vec  = '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
            valid_vec[i] = entry_q[i].valid;
            done_vec[i]  = entry_q[i].done;
        end
    end

    rob_retire_select u_select (
        .head  (head_q),
        .valid (valid_vec),
        .done  (done_vec),
        .n     (ret_n),
        .idx   (ret_idx)
    );

    // Only registered occupancy gates dispatch; a same-cycle retire gives no credit.
    assign rif.disp_ready = (count_q < CNT_W'(ROB_DEPTH));
    assign rif.disp_tag   = tail_q;
    assign rif.count      = count_q;
    assign rif.empty      = (count_q == '0);
    assign rif.RegWrite   = reg_write_q;
    assign rif.write_reg  = write_reg_q;
    assign rif.write_data = write_data_q;
    assign accept         = rif.disp_valid && rif.disp_ready;

    always_comb begin
        entry_d      = entry_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        reg_write_d  = '0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;

        if (rif.flush) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entry_d[i].valid = 1'b0;
                entry_d[i].done  = 1'b0;
            end
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Ascending port order lets the higher index win on a shared tag.
            for (int p = 0; p < COMPLETE_PORTS; p++) begin
                if (rif.cmpl_valid[p] && entry_q[rif.cmpl_tag[p]].valid) begin
                    entry_d[rif.cmpl_tag[p]].done = 1'b1;
                    entry_d[rif.cmpl_tag[p]].data = rif.cmpl_data[p];
                end
            end

            for (int k = 0; k < WRITE_PORTS; k++) begin
                if (k < int'(ret_n)) begin
                    reg_write_d[k]  = entry_q[ret_idx[k]].has_dest &&
                                      (entry_q[ret_idx[k]].dest != '0);
                    write_reg_d[k]  = entry_q[ret_idx[k]].dest;
                    write_data_d[k] = entry_q[ret_idx[k]].data;
                    entry_d[ret_idx[k]].valid = 1'b0;
                    entry_d[ret_idx[k]].done  = 1'b0;
                end
            end
            head_d = head_q + TAG_W'(ret_n);

            if (accept) begin
                entry_d[tail_q] = '{valid: 1'b1, done: 1'b0, has_dest: rif.disp_has_dest,
                                    dest: rif.disp_dest_reg, data: '0};
                tail_d = tail_q + TAG_W'(1);
            end
            count_d = count_q + CNT_W'(accept) - CNT_W'(ret_n);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            reg_write_q  <= '0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            for (int i = 0; i < ROB_DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end
endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: dispatch, out-of-order completion, retire width, flush, reset.
module tb_rob_commit;
    import rob_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rob_commit_if rif ();

    rob_commit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rif   (rif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rif.flush      = 1'b0;
        rif.disp_valid = 1'b0;
        rif.cmpl_valid = '0;
    endtask

    task automatic cmpl(input int p, input logic [TAG_W-1:0] t, input logic [SIZE-1:0] d);
        rif.cmpl_valid[p] = 1'b1;
        rif.cmpl_tag[p]   = t;
        rif.cmpl_data[p]  = d;
    endtask

    task automatic disp(input logic has, input logic [REG_W-1:0] dest,
                        input logic [TAG_W-1:0] exp_tag, input string tag);
        rif.disp_valid    = 1'b1;
        rif.disp_has_dest = has;
        rif.disp_dest_reg = dest;
        chk(tag, rif.disp_tag, exp_tag);
        tick();
        rif.disp_valid = 1'b0;
    endtask

    initial begin
        rif.flush         = 1'b0;
        rif.disp_valid    = 1'b0;
        rif.disp_has_dest = 1'b0;
        rif.disp_dest_reg = '0;
        rif.cmpl_valid    = '0;
        rif.cmpl_tag      = '0;
        rif.cmpl_data     = '0;

        // 1: reset and idle
        #12;
        chk("rst_regwrite", rif.RegWrite, 0);
        chk("rst_count", rif.count, 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("idle_regwrite", rif.RegWrite, 0);
        chk("idle_count", rif.count, 0);
        chk("idle_empty", rif.empty, 1);
        chk("idle_ready", rif.disp_ready, 1);
        chk("idle_tag", rif.disp_tag, 0);

        // 2: out-of-order completion, single 3-wide retire
        disp(1'b1, 6'd5, 4'd0, "t2_tag0");
        disp(1'b1, 6'd6, 4'd1, "t2_tag1");
        disp(1'b1, 6'd7, 4'd2, "t2_tag2");
        chk("t2_count", rif.count, 3);
        chk("t2_tail", rif.disp_tag, 3);
        cmpl(0, 4'd2, 32'hA); tick(); idle();
        chk("t2_noret_a", rif.RegWrite, 0);
        cmpl(0, 4'd1, 32'hB); tick(); idle();
        chk("t2_noret_b", rif.RegWrite, 0);
        cmpl(0, 4'd0, 32'hC); tick(); idle();
        chk("t2_latency", rif.RegWrite, 0);
        chk("t2_count_pre", rif.count, 3);
        tick();
        chk("t2_regwrite", rif.RegWrite, 3'b111);
        chk("t2_write_reg", rif.write_reg, {6'd7, 6'd6, 6'd5});
        chk("t2_write_data", rif.write_data, {32'hA, 32'hB, 32'hC});
        chk("t2_count_post", rif.count, 0);
        chk("t2_empty", rif.empty, 1);
        tick();
        chk("t2_regwrite_off", rif.RegWrite, 0);
        chk("t2_write_reg_hold", rif.write_reg, {6'd7, 6'd6, 6'd5});

        // 3: fill to full across the wrap, retire one, ready returns
        for (int i = 0; i < 16; i++) begin
            disp(1'b1, REG_W'(i + 1), TAG_W'(i + 3), "t3_tag");
        end
        chk("t3_full_count", rif.count, 16);
        chk("t3_full_ready", rif.disp_ready, 0);
        chk("t3_full_empty", rif.empty, 0);
        chk("t3_full_tail", rif.disp_tag, 3);
        rif.disp_valid = 1'b1;
        cmpl(0, 4'd3, 32'h33); tick(); idle();
        chk("t3_blocked_count", rif.count, 16);
        chk("t3_blocked_ready", rif.disp_ready, 0);
        rif.disp_valid = 1'b1;
        tick(); idle();
        chk("t3_ret_regwrite", rif.RegWrite, 3'b001);
        chk("t3_ret_reg", rif.write_reg[0], 1);
        chk("t3_ret_data", rif.write_data[0], 32'h33);
        chk("t3_ret_count", rif.count, 15);
        chk("t3_ready_back", rif.disp_ready, 1);
        chk("t3_tail_hold", rif.disp_tag, 3);
        rif.flush = 1'b1; tick(); idle();
        chk("t3_flush_count", rif.count, 0);
        chk("t3_flush_tag", rif.disp_tag, 0);
        chk("t3_flush_regwrite", rif.RegWrite, 0);

        // 4: retire 3 then 1; no-dest and r0 entries suppress the write
        disp(1'b1, 6'd10, 4'd0, "t4_tag0");
        disp(1'b0, 6'd11, 4'd1, "t4_tag1");
        disp(1'b1, 6'd0,  4'd2, "t4_tag2");
        disp(1'b1, 6'd12, 4'd3, "t4_tag3");
        cmpl(0, 4'd2, 32'h102); cmpl(1, 4'd3, 32'h103); tick(); idle();
        chk("t4_noret_a", rif.RegWrite, 0);
        cmpl(0, 4'd0, 32'h100); cmpl(1, 4'd1, 32'h101); tick(); idle();
        chk("t4_noret_b", rif.RegWrite, 0);
        chk("t4_count4", rif.count, 4);
        tick();
        chk("t4_r3_regwrite", rif.RegWrite, 3'b001);
        chk("t4_r3_reg", rif.write_reg, {6'd0, 6'd11, 6'd10});
        chk("t4_r3_data", rif.write_data, {32'h102, 32'h101, 32'h100});
        chk("t4_r3_count", rif.count, 1);
        tick();
        chk("t4_r1_regwrite", rif.RegWrite, 3'b001);
        chk("t4_r1_reg", rif.write_reg, {6'd0, 6'd11, 6'd12});
        chk("t4_r1_data", rif.write_data, {32'h102, 32'h101, 32'h103});
        chk("t4_r1_count", rif.count, 0);
        rif.flush = 1'b1; tick(); idle();

        // 5: same-tag completion on both ports; completion to undispatched tags
        disp(1'b1, 6'd20, 4'd0, "t5_tag0");
        disp(1'b1, 6'd21, 4'd1, "t5_tag1");
        disp(1'b1, 6'd22, 4'd2, "t5_tag2");
        disp(1'b1, 6'd23, 4'd3, "t5_tag3");
        cmpl(0, 4'd0, 32'h50); cmpl(1, 4'd1, 32'h51); tick(); idle();
        chk("t5_noret", rif.RegWrite, 0);
        cmpl(0, 4'd2, 32'h52); tick(); idle();
        chk("t5_r2_regwrite", rif.RegWrite, 3'b011);
        chk("t5_r2_reg", rif.write_reg, {6'd0, 6'd21, 6'd20});
        chk("t5_r2_data", rif.write_data, {32'h102, 32'h51, 32'h50});
        chk("t5_r2_count", rif.count, 2);
        cmpl(0, 4'd3, 32'h11); cmpl(1, 4'd3, 32'h22); tick(); idle();
        chk("t5_tag2_regwrite", rif.RegWrite, 3'b001);
        chk("t5_tag2_data", rif.write_data[0], 32'h52);
        rif.disp_valid    = 1'b1;
        rif.disp_has_dest = 1'b1;
        rif.disp_dest_reg = 6'd24;
        cmpl(0, 4'd9, 32'hDEAD); cmpl(1, 4'd4, 32'hBEEF); tick(); idle();
        chk("t5_dup_regwrite", rif.RegWrite, 3'b001);
        chk("t5_dup_reg", rif.write_reg[0], 23);
        chk("t5_dup_data", rif.write_data[0], 32'h22);
        chk("t5_dup_count", rif.count, 1);
        tick();
        chk("t5_inval_regwrite", rif.RegWrite, 0);
        tick();
        chk("t5_inval_regwrite2", rif.RegWrite, 0);
        chk("t5_inval_count", rif.count, 1);
        chk("t5_inval_tail", rif.disp_tag, 5);

        // 6: flush beats pending retire, completion and dispatch
        disp(1'b1, 6'd25, 4'd5, "t6_tag5");
        disp(1'b1, 6'd26, 4'd6, "t6_tag6");
        disp(1'b1, 6'd27, 4'd7, "t6_tag7");
        disp(1'b1, 6'd28, 4'd8, "t6_tag8");
        chk("t6_count5", rif.count, 5);
        cmpl(0, 4'd4, 32'h60); cmpl(1, 4'd5, 32'h61); tick(); idle();
        rif.flush      = 1'b1;
        rif.disp_valid = 1'b1;
        cmpl(0, 4'd6, 32'h62); cmpl(1, 4'd7, 32'h63);
        tick(); idle();
        chk("t6_flush_count", rif.count, 0);
        chk("t6_flush_regwrite", rif.RegWrite, 0);
        chk("t6_flush_tag", rif.disp_tag, 0);
        chk("t6_flush_empty", rif.empty, 1);
        tick();
        chk("t6_after_regwrite", rif.RegWrite, 0);
        chk("t6_after_count", rif.count, 0);

        // asynchronous reset mid-retire
        disp(1'b1, 6'd30, 4'd0, "t6r_tag0");
        disp(1'b1, 6'd31, 4'd1, "t6r_tag1");
        disp(1'b1, 6'd32, 4'd2, "t6r_tag2");
        cmpl(0, 4'd0, 32'h70); cmpl(1, 4'd1, 32'h71); tick(); idle();
        cmpl(0, 4'd2, 32'h72); tick(); idle();
        chk("t6r_pre_regwrite", rif.RegWrite, 3'b011);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6r_regwrite", rif.RegWrite, 0);
        chk("t6r_write_reg", rif.write_reg, 0);
        chk("t6r_write_data", rif.write_data, 0);
        chk("t6r_count", rif.count, 0);
        chk("t6r_tag", rif.disp_tag, 0);
        #1;
        rst_n = 1'b1;
        tick();
        chk("t6r_post_regwrite", rif.RegWrite, 0);
        chk("t6r_post_count", rif.count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
In-order commit stage that feeds the 3-write-port register file. It holds dispatched instructions in a circular reorder buffer and accepts out-of-order completion results on COMPLETE_PORTS ports. Each cycle it retires up to WRITE_PORTS consecutive completed entries from the head, driving RegWrite/write_reg/write_data in program order. It sits between the execution units and the register file write interface.

Parameters:
SIZE, 32, data width; matches register file.
REG_NUM, 64, architectural register count; REG_W = $clog2(REG_NUM).
ROB_DEPTH, 16, entry count; power of two; TAG_W = $clog2(ROB_DEPTH).
COMPLETE_PORTS, 2, completion ports.
WRITE_PORTS, 3, retire width; must equal register file WRITE_PORTS.

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all entries
disp_valid  in  1  dispatch request
disp_has_dest  in  1  instruction writes a register
disp_dest_reg  in  REG_W  destination register
disp_ready  out  1  dispatch accepted when disp_valid && disp_ready
disp_tag  out  TAG_W  tag of the entry the current dispatch will take (tail)
cmpl_valid  in  [COMPLETE_PORTS]  completion strobes
cmpl_tag  in  [COMPLETE_PORTS][TAG_W]  completing entry
cmpl_data  in  [COMPLETE_PORTS][SIZE]  result
RegWrite  out  [WRITE_PORTS]  register file write enables, registered
write_reg  out  [WRITE_PORTS][REG_W]  registered
write_data  out  [WRITE_PORTS][SIZE]  registered
count  out  TAG_W+1  occupied entries
empty  out  1  count == 0

Behaviour:
- Reset (rst_n low, asynchronous): head = tail = count = 0, all entry valid/done = 0, RegWrite = 0, write_reg = 0, write_data = 0. Reset mid-operation discards all entries.
- Entry fields: valid, done, has_dest, dest, data.
- disp_ready = (count < ROB_DEPTH), computed from registered count only. No same-cycle credit from retirement, so disp_ready stays 0 when full even if a retire occurs that cycle.
- disp_tag = tail. On accept: entry[tail] <= {valid=1, done=0, has_dest, dest, data=0}, tail <= tail+1 mod ROB_DEPTH.
- Completion on port p: if entry[cmpl_tag[p]].valid, set done=1 and data=cmpl_data[p]. Completion to an invalid entry is ignored. Two ports with the same tag in one cycle: the higher port index wins.
- done becomes visible on the cycle after the completion edge. An entry never completes and retires in the same cycle.
- Retire selection (combinational, on registered state): n = number of consecutive entries from head, up to WRITE_PORTS and up to count, with valid && done. Selection stops at the first not-done entry.
- At the edge, for k < n:
  - RegWrite[k] <= has_dest && dest != 0.
  - write_reg[k] <= dest; write_data[k] <= data.
  - Clear entry valid/done.
- For k >= n: RegWrite[k] <= 0; write_reg/write_data hold their previous value.
- head <= head+n. count <= count + accept - n.
- Port 0 is always the oldest entry. Same-register writes in one cycle therefore resolve youngest-wins in the register file.
- Latency: completion at edge E, RegWrite asserted after edge E+1, register file updated at edge E+2. An entry with has_dest = 0 retires with no write.
- Wrap-around: head/tail wrap modulo ROB_DEPTH. count distinguishes full from empty.
- flush: highest priority. Clears all entries, head = tail = count = 0, RegWrite <= 0 at the same edge. Dispatch, completion and retire in a flush cycle are discarded.

Decomposition:
- Package rob_pkg holds:
  - localparams TAG_W and REG_W.
  - rob_entry_t packed struct {valid, done, has_dest, dest, data}.
- One sub-module, rob_retire_select: combinational. Takes the head and the entry valid/done vectors; outputs n and the per-slot entry indices.

Test Plan:
1. Reset then idle: RegWrite = 0, count = 0, empty = 1, disp_ready = 1, disp_tag = 0.
2. Dispatch tags 0,1,2 (dest 5,6,7). Complete in order 2,1,0 with data 0xA,0xB,0xC, one per cycle. No retire until tag 0 is done; then a single cycle with RegWrite = 3'b111, write_reg = {7,6,5}, write_data = {0xA,0xB,0xC}.
3. Dispatch 16 entries: disp_ready = 0, count = 16. Complete tag 0: disp_ready returns 1 the cycle after the retire. Continue until tail wraps to 0 and the next disp_tag = 0.
4. Dispatch 4 entries, complete all. Retire 3 then 1 on consecutive cycles. An entry with has_dest = 0 or dest = 0 retires with RegWrite bit 0.
5. Both completion ports hit tag 3 with 0x11 (port 0) and 0x22 (port 1): retired write_data = 0x22. Completion to an undispatched tag changes nothing.
6. flush with 5 entries pending and cmpl_valid high: next cycle count = 0, RegWrite = 0, disp_tag = 0. Repeat with rst_n pulsed low mid-retire: outputs go to 0 immediately.
